// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage arbitrating MEM and muldiv results into the register file
// MEM normally wins the single write port; a starved muldiv result forces a one-cycle upstream stall.
module wb_stage #(
  parameter int XLEN         = 32,
  parameter int RAW          = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic              mem_we_i,
  input  logic [RAW-1:0]    mem_rd_i,
  input  logic              mem_is_load_i,
  input  logic [2:0]        mem_funct3_i,
  input  logic [1:0]        mem_addr_lo_i,
  input  logic [XLEN-1:0]   mem_alu_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  input  logic              md_valid_i,
  input  logic [RAW-1:0]    md_rd_i,
  input  logic [XLEN-1:0]   md_result_i,
  output logic              md_ready_o,
  input  logic              issue_valid_i,
  input  logic [RAW-1:0]    issue_rd_i,
  output logic [2**RAW-1:0] busy_o,
  output logic              stall_o,
  output logic              we_o,
  output logic [RAW-1:0]    waddr_o,
  output logic [XLEN-1:0]   wdata_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic            mem_cand, md_cand, mem_accept, md_accept;
  logic [CW-1:0]   starve_q, starve_d;
  logic            stall_d;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] mem_data;
  logic [2**RAW-1:0] set_mask, clr_mask, busy_d;

  assign mem_cand    = mem_valid_i && mem_we_i && (mem_rd_i != '0);
  assign md_cand     = md_valid_i && (md_rd_i != '0);
  assign mem_ready_o = !stall_o;
  assign mem_accept  = mem_cand && !stall_o;
  assign md_ready_o  = !mem_accept || stall_o;
  assign md_accept   = md_valid_i && md_ready_o;

  always_comb begin
    byte_sel = mem_rdata_i[7:0];
    case (mem_addr_lo_i)
      2'd1:    byte_sel = mem_rdata_i[15:8];
      2'd2:    byte_sel = mem_rdata_i[23:16];
      2'd3:    byte_sel = mem_rdata_i[31:24];
      default: byte_sel = mem_rdata_i[7:0];
    endcase
    half_sel = mem_addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    mem_data = mem_alu_i;
    if (mem_is_load_i) begin
      case (mem_funct3_i)
        3'b000:  mem_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
        3'b001:  mem_data = {{(XLEN-16){half_sel[15]}}, half_sel};
        3'b100:  mem_data = {{(XLEN-8){1'b0}}, byte_sel};
        3'b101:  mem_data = {{(XLEN-16){1'b0}}, half_sel};
        default: mem_data = mem_rdata_i;
      endcase
    end
  end

  // Stall is raised on the same edge the counter saturates, so it is visible the next cycle.
  always_comb begin
    starve_d = starve_q;
    if (md_accept || !md_valid_i)
      starve_d = '0;
    else if (md_cand && starve_q != CW'(STARVE_LIMIT))
      starve_d = starve_q + 1'b1;
    stall_d = (starve_d == CW'(STARVE_LIMIT));
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid_i && issue_rd_i != '0)
      set_mask[issue_rd_i] = 1'b1;
    if (md_accept)
      clr_mask[md_rd_i] = 1'b1;
    busy_d    = (busy_o & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_o     <= 1'b0;
      waddr_o  <= '0;
      wdata_o  <= '0;
      busy_o   <= '0;
      stall_o  <= 1'b0;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      stall_o  <= stall_d;
      busy_o   <= busy_d;
      we_o     <= 1'b0;
      if (mem_accept) begin
        we_o    <= 1'b1;
        waddr_o <= mem_rd_i;
        wdata_o <= mem_data;
      end else if (md_accept && md_cand) begin
        we_o    <= 1'b1;
        waddr_o <= md_rd_i;
        wdata_o <= md_result_i;
      end
    end
  end

endmodule
